z80_mem_arbiter: RTL

Z80_MEM_ARBITER -- requirements
Module: z80_mem_arbiter

---
 rtl/z80_mem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/z80_mem_arbiter.sv
// Z80 / DMA shared-RAM arbiter.
// Two requesters share one synchronous single-port RAM. Each access is an
// issue cycle (RAM enable) followed by a data cycle. Ties are resolved
// round-robin. The CPU is stalled through WAIT until its access completes.
module z80_mem_arbiter #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    // Z80 side
    input  logic              i_cpu_mreq,
    input  logic              i_cpu_wr,
    input  logic [15:0]       i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_do,
    output logic [DATA_W-1:0] o_cpu_di,
    output logic              o_cpu_wait,
    // DMA / loader side
    input  logic              i_dma_req,
    input  logic              i_dma_we,
    input  logic [ADDR_W-1:0] i_dma_addr,
    input  logic [DATA_W-1:0] i_dma_wdata,
    output logic              o_dma_ack,
    output logic [DATA_W-1:0] o_dma_rdata,
    // RAM side
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        CPU_ISS,
        CPU_DAT,
        DMA_ISS,
        DMA_DAT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              last_dma;      // 1 when the DMA port was served last
    logic              cpu_served;    // current mreq assertion already got its access
    logic              cpu_pend;
    logic              dma_pend;
    logic              prefer_cpu;
    logic [DATA_W-1:0] cpu_di_q;
    logic [DATA_W-1:0] dma_rdata_q;

    // CPU_DAT is the access being completed, so it is not pending again.
    assign cpu_pend = i_cpu_mreq && !cpu_served && (state != CPU_DAT);
    assign dma_pend = i_dma_req;

    // Arbitrating out of a DAT state uses the grant being completed right now,
    // since last_dma only updates at the end of that cycle.
    assign prefer_cpu = (state == DMA_DAT) ? 1'b1 :
                        (state == CPU_DAT) ? 1'b0 : last_dma;

    // Reset gating keeps WAIT low while the arbiter is held in reset.
    assign o_cpu_wait = i_reset_n && cpu_pend;

    assign o_cpu_di = cpu_di_q;

    // DMA read data follows the RAM output during the ack cycle, then holds.
    assign o_dma_rdata = (state == DMA_DAT) ? i_mem_rdata : dma_rdata_q;

    // Next-state selection and RAM/ack drive.
    always_comb begin
        state_nx    = state;
        o_mem_en    = 1'b0;
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        o_dma_ack   = 1'b0;
        case (state)
            IDLE, CPU_DAT, DMA_DAT: begin
                o_dma_ack = (state == DMA_DAT);
                if (cpu_pend && (!dma_pend || prefer_cpu)) begin
                    state_nx = CPU_ISS;
                end else if (dma_pend) begin
                    state_nx = DMA_ISS;
                end else begin
                    state_nx = IDLE;
                end
            end
            CPU_ISS: begin
                o_mem_en    = 1'b1;
                o_mem_we    = i_cpu_wr;
                o_mem_addr  = i_cpu_addr[ADDR_W-1:0];
                o_mem_wdata = i_cpu_do;
                state_nx    = CPU_DAT;
            end
            DMA_ISS: begin
                o_mem_en    = 1'b1;
                o_mem_we    = i_dma_we;
                o_mem_addr  = i_dma_addr;
                o_mem_wdata = i_dma_wdata;
                state_nx    = DMA_DAT;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register, grant history, CPU served flag and read-data capture.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            last_dma    <= 1'b1;
            cpu_served  <= 1'b0;
            cpu_di_q    <= '0;
            dma_rdata_q <= '0;
        end else begin
            state <= state_nx;
            if (!i_cpu_mreq) begin
                cpu_served <= 1'b0;
            end else if (state == CPU_DAT) begin
                cpu_served <= 1'b1;
            end
            if (state == CPU_DAT) begin
                cpu_di_q <= i_mem_rdata;
                last_dma <= 1'b0;
            end
            if (state == DMA_DAT) begin
                dma_rdata_q <= i_mem_rdata;
                last_dma    <= 1'b1;
            end
        end
    end

endmodule
